pulse_handshake_tx: RTL and testbench

- Source-side end of the cross-domain pulse transfer.
- Converts one-cycle event pulses in its own clock domain into a 4-phase req/ack handshake toward a destination clock domain.
- The destination side edge-detects req_o into its own one-cycle pulse and returns ack_i as a level.
- Queues events that arrive while a handshake is in flight, so no pulse is lost up to a bounded depth; reports completion and overflow locally.

---
 rtl/pulse_handshake_tx.sv | 95 +++++++++
 tb/tb_pulse_handshake_tx.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_handshake_tx.sv
// rtl/pulse_handshake_tx.sv - source side of a 4-phase req/ack pulse transfer with event queue
module pulse_handshake_tx #(
  parameter int SYNC_STAGES = 2,
  parameter int PENDING_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pulse_i,
  input  logic                 clr_overflow_i,
  input  logic                 ack_i,
  output logic                 req_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [PENDING_W-1:0] pending_o,
  output logic                 overflow_o
);

  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

  localparam logic [PENDING_W-1:0] PEND_MAX = '1;

  state_t                 state;
  state_t                 state_nx;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic [PENDING_W-1:0]   pending;
  logic [PENDING_W-1:0]   pending_nx;
  logic                   overflow;
  logic                   overflow_nx;
  logic                   req;
  logic                   req_nx;
  logic                   start;
  logic                   direct;
  logic                   inc;
  logic                   dec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_i};
    end
  end

  assign ack_s = ack_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      req      <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      req      <= req_nx;
      pending  <= pending_nx;
      overflow <= overflow_nx;
    end
  end

  // A stale ack (ack_s still high in IDLE) blocks a new request; the pulse is queued instead.
  always_comb begin
    start  = (state == IDLE) && !ack_s && (pulse_i || (pending != '0));
    direct = (state == IDLE) && !ack_s && pulse_i && (pending == '0);
    inc    = pulse_i && !direct;
    dec    = start && (pending != '0);

    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = REQ;
      REQ:     if (ack_s) state_nx = RELEASE;
      RELEASE: if (!ack_s) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    req_nx = (state_nx == REQ);

    pending_nx  = pending;
    overflow_nx = overflow;
    if (clr_overflow_i) overflow_nx = 1'b0;
    if (inc && !dec) begin
      if (pending == PEND_MAX) overflow_nx = 1'b1;
      else                     pending_nx  = pending + 1'b1;
    end else if (dec && !inc) begin
      pending_nx = pending - 1'b1;
    end
  end

  // Outputs decode registered state only, so ack_i has no combinational path out.
  assign req_o      = req;
  assign done_o     = (state == RELEASE) && !ack_s;
  assign busy_o     = (state != IDLE) || (pending != '0);
  assign pending_o  = pending;
  assign overflow_o = overflow;

endmodule

// File: tb/tb_pulse_handshake_tx.sv
// tb/tb_pulse_handshake_tx.sv - directed scoreboard bench for pulse_handshake_tx
module tb_pulse_handshake_tx;

  localparam int SS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       pulse_a = 1'b0, clr_a = 1'b0, ack_a = 1'b0;
  logic       req_a, busy_a, done_a, ovf_a;
  logic [3:0] pend_a;

  logic       pulse_b = 1'b0, clr_b = 1'b0, ack_b = 1'b0;
  logic       req_b, busy_b, done_b, ovf_b;
  logic [1:0] pend_b;

  logic [2:0] hist_a = '0, hist_b = '0;
  logic       force_a = 1'b0, fval_a = 1'b0;
  logic       force_b = 1'b0, fval_b = 1'b0;

  int q_a[$];
  int q_b[$];
  int n_checks = 0;
  int n_fail = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  int exp_a, exp_b;
  int start_cnt, n;

  always #5 clk = ~clk;

  pulse_handshake_tx #(.SYNC_STAGES(SS), .PENDING_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .pulse_i(pulse_a), .clr_overflow_i(clr_a), .ack_i(ack_a),
    .req_o(req_a), .busy_o(busy_a), .done_o(done_a), .pending_o(pend_a), .overflow_o(ovf_a)
  );

  pulse_handshake_tx #(.SYNC_STAGES(SS), .PENDING_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .pulse_i(pulse_b), .clr_overflow_i(clr_b), .ack_i(ack_b),
    .req_o(req_b), .busy_o(busy_b), .done_o(done_b), .pending_o(pend_b), .overflow_o(ovf_b)
  );

  // Destination models: ack follows req three cycles later unless forced.
  always @(negedge clk) begin
    hist_a = {hist_a[1:0], req_a};
    ack_a  = force_a ? fval_a : hist_a[2];
    hist_b = {hist_b[1:0], req_b};
    ack_b  = force_b ? fval_b : hist_b[2];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done_a) begin
        done_cnt_a++;
        chk("a_done_expected", q_a.size() != 0, 1);
        if (q_a.size() != 0) begin
          exp_a = q_a.pop_front();
          chk("a_pending_at_done", pend_a, exp_a);
        end
      end
      if (done_b) begin
        done_cnt_b++;
        chk("b_done_expected", q_b.size() != 0, 1);
        if (q_b.size() != 0) begin
          exp_b = q_b.pop_front();
          chk("b_pending_at_done", pend_b, exp_b);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done_a(input string tag);
    int k = 0;
    while (!done_a && k < 100) begin tick(); k++; end
    chk(tag, done_a, 1);
  endtask

  task automatic drain_a(input string tag);
    int k = 0;
    while ((q_a.size() != 0 || busy_a) && k < 600) begin tick(); k++; end
    chk(tag, (q_a.size() != 0) || busy_a, 0);
  endtask

  task automatic drain_b(input string tag);
    int k = 0;
    while ((q_b.size() != 0 || busy_b) && k < 600) begin tick(); k++; end
    chk(tag, (q_b.size() != 0) || busy_b, 0);
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, "_req"}, req_a, 0);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_pending"}, pend_a, 0);
    chk({tag, "_overflow"}, ovf_a, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk_a_zero("reset");
    chk("reset_b_pending", pend_b, 0);
    chk("reset_b_req", req_b, 0);
    rst_n = 1'b1;
    repeat (5) tick();

    // single event
    pulse_a = 1'b1;
    q_a.push_back(0);
    tick();
    pulse_a = 1'b0;
    chk("t1_req_rise", req_a, 1);
    chk("t1_pending", pend_a, 0);
    chk("t1_busy", busy_a, 1);
    n = 0;
    while (!ack_a && n < 50) begin tick(); n++; end
    chk("t1_ack_seen", ack_a, 1);
    n = 1;
    while (req_a && n < 20) begin tick(); n++; end
    chk("t1_req_fall_latency", n, SS + 1);
    wait_done_a("t1_done");
    tick();
    chk("t1_done_single", done_a, 0);
    chk("t1_busy_low", busy_a, 0);
    chk("t1_sb_empty", q_a.size(), 0);

    // burst of five
    start_cnt = done_cnt_a;
    pulse_a = 1'b1;
    for (int k = 0; k < 5; k++) begin
      q_a.push_back(4 - k);
      tick();
      if (k == 0) begin
        chk("t2_first_req", req_a, 1);
        chk("t2_first_pending", pend_a, 0);
      end
    end
    pulse_a = 1'b0;
    chk("t2_pending_peak", pend_a, 4);
    drain_a("t2_drain");
    chk("t2_done_count", done_cnt_a - start_cnt, 5);
    chk("t2_no_overflow", ovf_a, 0);

    // stale ack, then pulse coinciding with dequeue
    force_a = 1'b1;
    fval_a  = 1'b1;
    repeat (4) tick();
    pulse_a = 1'b1;
    tick();
    pulse_a = 1'b0;
    chk("t5_req_stays_low", req_a, 0);
    chk("t5_pending_one", pend_a, 1);
    tick();
    pulse_a = 1'b1;
    tick();
    pulse_a = 1'b0;
    chk("t5_pending_two", pend_a, 2);
    chk("t5_req_still_low", req_a, 0);
    chk("t5_busy_pending", busy_a, 1);
    q_a.push_back(2);
    q_a.push_back(1);
    q_a.push_back(0);
    force_a = 1'b0;
    for (int k = 0; k < SS; k++) begin
      tick();
      chk("t5_req_wait", req_a, 0);
    end
    pulse_a = 1'b1;
    tick();
    pulse_a = 1'b0;
    chk("t5_req_rise_after_ack_drop", req_a, 1);
    chk("t4_pending_hold", pend_a, 2);
    drain_a("t4_drain");

    // overflow on the narrow instance
    start_cnt = done_cnt_b;
    force_b = 1'b1;
    fval_b  = 1'b0;
    tick();
    pulse_b = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 3) begin
        chk("t3_full_pending", pend_b, 3);
        chk("t3_full_no_ovf", ovf_b, 0);
      end
    end
    pulse_b = 1'b0;
    chk("t3_sat_pending", pend_b, 3);
    chk("t3_overflow_set", ovf_b, 1);
    chk("t3_req_held", req_b, 1);
    for (int k = 3; k >= 0; k--) q_b.push_back(k);
    force_b = 1'b0;
    drain_b("t3_drain");
    chk("t3_done_count", done_cnt_b - start_cnt, 4);
    chk("t3_overflow_sticky", ovf_b, 1);
    clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    chk("t3_overflow_cleared", ovf_b, 0);
    force_b = 1'b1;
    fval_b  = 1'b0;
    pulse_b = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) clr_b = 1'b1;
      tick();
    end
    pulse_b = 1'b0;
    clr_b   = 1'b0;
    chk("t3_set_beats_clear", ovf_b, 1);
    chk("t3_pending_again", pend_b, 3);
    for (int k = 3; k >= 0; k--) q_b.push_back(k);
    force_b = 1'b0;
    drain_b("t3_drain2");
    clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    chk("t3_final_clear", ovf_b, 0);

    // async reset in REQ
    pulse_a = 1'b1;
    q_a.push_back(0);
    tick();
    pulse_a = 1'b0;
    chk("t6_req_before_reset", req_a, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_a_zero("t6_reset_in_req");
    q_a.delete();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (10) tick();

    // async reset in RELEASE
    pulse_a = 1'b1;
    q_a.push_back(0);
    tick();
    pulse_a = 1'b0;
    n = 0;
    while (req_a && n < 50) begin tick(); n++; end
    chk("t6_in_release", req_a, 0);
    chk("t6_release_busy", busy_a, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_a_zero("t6_reset_in_release");
    q_a.delete();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (10) tick();

    // fresh event after reset
    pulse_a = 1'b1;
    q_a.push_back(0);
    tick();
    pulse_a = 1'b0;
    chk("t6_fresh_req", req_a, 1);
    wait_done_a("t6_fresh_done");
    tick();
    chk("t6_fresh_idle", busy_a, 0);
    chk("t6_sb_empty", q_a.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
